spi_reg_responder: RTL
======================

Name: spi_reg_responder

Overview:
SPI mode-0 slave (responder) with a 32 x 8 register file. It is the far end of the SoC's SPI master link (MOSI/SCLK/SS_n driven by the master, MISO returned). Command/data framing is MAX3421E-style. The block lets the Nios-side SPI driver exchange keycode and status bytes with fabric logic, and the fabric reads and writes the same register file through a local port.

Parameters:
ADDR_W, 5, register address width; register count = 2**ADDR_W.
SYNC_STAGES, 2, flip-flop stages on SCLK/MOSI/SS_n before edge detection (min 2).

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
spi_sclk  in  1  SPI clock from master (CPOL=0)
spi_mosi  in  1  master-out data, MSB first
spi_ss_n  in  1  active-low slave select
spi_miso  out  1  slave-out data, MSB first
spi_miso_oe  out  1  high while a frame is active (tri-state enable)
fab_addr  in  ADDR_W  fabric register address
fab_wdata  in  8  fabric write data
fab_we  in  1  fabric write strobe
fab_rdata  out  8  regfile[fab_addr], registered, 1-cycle latency
spi_wr_valid  out  1  one-cycle pulse per SPI-written byte
spi_wr_addr  out  ADDR_W  address of that write
spi_wr_data  out  8  data of that write
frame_active  out  1  high from SS_n fall to SS_n rise (synchronized)

Behaviour:
- Reset: all outputs 0, all registers 0x00, state IDLE, counters 0.
- SCLK, MOSI and SS_n each pass through SYNC_STAGES flops. Edges are detected on synced SCLK, and MOSI is sampled from the same pipeline depth. Requirement: f_sclk <= f_clk/8.
- States: IDLE, CMD, DATA.
- IDLE -> CMD on synced SS_n falling edge. On that edge: load tx_shift <= reg[0] (status byte), bit_cnt <= 0, assert frame_active and spi_miso_oe.
- Synced SCLK rising edge: rx_shift <= {rx_shift[6:0], mosi}; bit_cnt increments mod 8.
- Synced SCLK falling edge: if bit_cnt==0 (byte boundary just crossed), load tx_shift with the next byte; otherwise shift tx_shift left. spi_miso = tx_shift[7].
- Completing the CMD byte (8th rising edge): addr <= cmd[7:3], wr_mode <= cmd[1]; other command bits are ignored. State -> DATA. The next tx byte is reg[addr] in read mode and 0x00 in write mode.
- Completing a DATA byte:
  - Write mode: reg[addr] <= rx byte; pulse spi_wr_valid with spi_wr_addr=addr and spi_wr_data=rx byte, on the cycle after the edge is detected.
  - Read mode: the next tx byte is reg[addr+1].
  - In both modes addr <= addr+1, wrapping from 2**ADDR_W-1 to 0.
- Read data is sampled at the tx load instant. A fabric write after that instant appears only on the following read.
- SS_n rise in any state: go to IDLE the same cycle; discard any partial byte (no write, no pulse); deassert frame_active and spi_miso_oe; spi_miso <= 0.
- SCLK edges while SS_n is high are ignored.
- Same-cycle SPI write and fab_we to the same address: the SPI write wins. Different addresses: both take effect.
- fab_rdata = reg[fab_addr] one cycle after the address is presented. It reflects writes committed in earlier cycles.
- Asynchronous reset mid-frame: immediate return to reset state. The frame resumes only after a fresh SS_n falling edge.

Test Plan:
1. Reset asserted mid-run -> all outputs 0; fab_rdata reads 0x00 at addresses 0, 3 and 31.
2. SPI frame: cmd 0x1A (addr 3, write), data 0x5A, 0xC3 -> spi_wr_valid pulses twice (addr 3/0x5A, then addr 4/0xC3); fab_rdata reads reg3=0x5A and reg4=0xC3.
3. Fabric writes reg0=0x81 and reg3=0xA5; SPI cmd 0x18 (addr 3, read), then 2 dummy bytes -> MISO returns 0x81 during cmd, then 0xA5, then reg4; no spi_wr_valid pulses.
4. Wrap: cmd 0xFA (addr 31, write), data 0x11, 0x22 -> reg31=0x11, reg0=0x22, second pulse has spi_wr_addr=0.
5. Abort: cmd 0x2A (addr 5, write), 5 data bits, then SS_n high -> no pulse, reg5 unchanged, frame_active falls; the next frame decodes normally.
6. Collision: an SPI write of 0x77 to addr 5 commits in the same cycle as fab_we with fab_addr=5 and fab_wdata=0x99 -> reg5=0x77.

Source files
------------

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder with a 2**ADDR_W x 8 register file shared with a fabric port.
// Framing: first byte is the command (addr in [7:3], write flag in [1]), following bytes are data.
module spi_reg_responder #(
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_ss_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [ADDR_W-1:0] fab_addr,
  input  logic [7:0]        fab_wdata,
  input  logic              fab_we,
  output logic [7:0]        fab_rdata,
  output logic              spi_wr_valid,
  output logic [ADDR_W-1:0] spi_wr_addr,
  output logic [7:0]        spi_wr_data,
  output logic              frame_active
);

  localparam int NREGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SYNC_STAGES-1:0]  r_sclk_sync;
  logic [SYNC_STAGES-1:0]  r_mosi_sync;
  logic [SYNC_STAGES-1:0]  r_ss_sync;
  logic                    r_sclk_prev;
  logic                    r_ss_prev;
  logic [7:0]              r_rx_shift;
  logic [7:0]              r_tx_shift;
  logic [2:0]              r_bit_cnt;
  logic [ADDR_W-1:0]       r_addr;
  logic                    r_wr_mode;
  logic                    r_frame_active;
  logic [7:0]              r_regs [NREGS];

  logic       w_sclk_s;
  logic       w_mosi_s;
  logic       w_ss_s;
  logic       w_ss_fall;
  logic       w_ss_rise;
  logic       w_in_frame;
  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_byte_done;
  logic       w_spi_commit;
  logic [7:0] w_rx_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_sync   <= '0;
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss_n};
      r_sclk_prev <= w_sclk_s;
      r_ss_prev   <= w_ss_s;
    end
  end

  assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss_s    = r_ss_sync[SYNC_STAGES-1];
  assign w_ss_fall = r_ss_prev & ~w_ss_s;
  assign w_ss_rise = ~r_ss_prev & w_ss_s;

  // SCLK edges only count inside a frame whose select is still low.
  assign w_in_frame  = (r_state != ST_IDLE) & ~w_ss_s;
  assign w_sclk_rise = w_in_frame & w_sclk_s & ~r_sclk_prev;
  assign w_sclk_fall = w_in_frame & ~w_sclk_s & r_sclk_prev;
  assign w_byte_done = w_sclk_rise & (r_bit_cnt == 3'd7);
  assign w_rx_byte   = {r_rx_shift[6:0], w_mosi_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_spi_commit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt = ST_CMD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (w_ss_rise) begin
          w_state_nxt = ST_IDLE;
        end else if (w_byte_done) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_CMD;
        end
      end
      ST_DATA: begin
        if (w_ss_rise) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt  = ST_DATA;
          w_spi_commit = w_byte_done & r_wr_mode;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_shift     <= 8'h00;
      r_tx_shift     <= 8'h00;
      r_bit_cnt      <= 3'd0;
      r_addr         <= '0;
      r_wr_mode      <= 1'b0;
      r_frame_active <= 1'b0;
      spi_wr_valid   <= 1'b0;
      spi_wr_addr    <= '0;
      spi_wr_data    <= 8'h00;
    end else begin
      spi_wr_valid <= 1'b0;
      if (w_ss_rise) begin
        r_tx_shift     <= 8'h00;
        r_bit_cnt      <= 3'd0;
        r_frame_active <= 1'b0;
      end else if ((r_state == ST_IDLE) && w_ss_fall) begin
        r_tx_shift     <= r_regs[0];
        r_bit_cnt      <= 3'd0;
        r_frame_active <= 1'b1;
      end else begin
        if (w_sclk_rise) begin
          r_rx_shift <= w_rx_byte;
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (w_byte_done) begin
            if (r_state == ST_CMD) begin
              r_addr    <= ADDR_W'(w_rx_byte[7:3]);
              r_wr_mode <= w_rx_byte[1];
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
              if (r_wr_mode) begin
                spi_wr_valid <= 1'b1;
                spi_wr_addr  <= r_addr;
                spi_wr_data  <= w_rx_byte;
              end
            end
          end
        end
        // A falling edge with bit_cnt==0 in DATA means a byte just completed: fetch the next one.
        if (w_sclk_fall) begin
          if ((r_bit_cnt == 3'd0) && (r_state == ST_DATA)) begin
            r_tx_shift <= r_wr_mode ? 8'h00 : r_regs[r_addr];
          end else begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          end
        end
      end
    end
  end

  // SPI write is applied after the fabric write so it wins on an address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= 8'h00;
      end
      fab_rdata <= 8'h00;
    end else begin
      if (fab_we) begin
        r_regs[fab_addr] <= fab_wdata;
      end
      if (w_spi_commit) begin
        r_regs[r_addr] <= w_rx_byte;
      end
      fab_rdata <= r_regs[fab_addr];
    end
  end

  assign spi_miso     = r_tx_shift[7];
  assign spi_miso_oe  = r_frame_active;
  assign frame_active = r_frame_active;

endmodule
